morse_player: RTL and testbench

Playback sequencer that drains the 20-bit symbol buffer and keys the Morse output. Pops one buffered character entry at a time with a single-cycle read strobe. Expands the entry into dot, dash and gap intervals using standard 1/3/1/3/7 unit timing. Drives the key line consumed by the LED/tone stage.

---
 rtl/morse_player_pkg.sv | 26 ++
 rtl/morse_player_unit_tick.sv | 30 +++
 rtl/morse_player.sv | 135 +++++++++++++
 tb/tb_morse_player.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/morse_player_pkg.sv
// Shared constants and state encoding for the Morse playback sequencer.
package morse_pkg;

  localparam logic [1:0] SYM_END  = 2'b00;
  localparam logic [1:0] SYM_DOT  = 2'b01;
  localparam logic [1:0] SYM_DASH = 2'b10;
  localparam logic [1:0] SYM_WORD = 2'b11;

  localparam int unsigned DOT_UNITS        = 1;
  localparam int unsigned DASH_UNITS       = 3;
  localparam int unsigned INTRA_UNITS      = 1;
  localparam int unsigned CHAR_EXTRA_UNITS = 2;
  localparam int unsigned WORD_UNITS       = 7;

  localparam int unsigned ELEMS_PER_ENTRY  = 10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_MARK,
    ST_SPACE,
    ST_CHAR_GAP,
    ST_WORD_GAP
  } state_t;

endpackage

// File: rtl/morse_player_unit_tick.sv
// Unit-time prescaler: pulses o_tick once every UNIT_CYCLES clocks,
// held at zero while i_restart is high.
module unit_tick #(
  parameter int unsigned UNIT_CYCLES = 12_000_000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_restart,
  output logic o_tick
);

  localparam int unsigned W = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
  localparam logic [W-1:0] LAST = W'(UNIT_CYCLES - 1);

  logic [W-1:0] r_cnt;

  // Free-running count that wraps after UNIT_CYCLES clocks.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_restart) begin
      r_cnt <= '0;
    end else if (r_cnt == LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_tick = (r_cnt == LAST);

endmodule

// File: rtl/morse_player.sv
// Morse playback sequencer: pops one 20-bit entry from the symbol buffer
// and keys it out using 1/3/1/3/7 unit timing.
module morse_player
  import morse_pkg::*;
#(
  parameter int unsigned UNIT_CYCLES = 12_000_000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_enable,
  input  logic        i_valid,
  input  logic [19:0] i_r_data,
  output logic        o_r_next,
  output logic        o_key,
  output logic        o_busy
);

  state_t      r_state;
  logic [19:0] r_shreg;
  logic [3:0]  r_elems;
  logic [2:0]  r_units;
  logic        r_key;
  logic        r_next;
  logic        r_busy;

  logic        w_tick;
  logic        w_restart;
  logic        w_expire;
  logic [1:0]  w_sym;

  // The prescaler is held in IDLE/LOAD. Timed states hand over to each other
  // exactly on a tick, where the prescaler wraps to zero by itself, so every
  // timed state still begins with a fresh unit.
  assign w_restart = (r_state == ST_IDLE) || (r_state == ST_LOAD);
  assign w_expire  = w_tick && (r_units == 3'd1);
  assign w_sym     = r_shreg[1:0];

  unit_tick #(
    .UNIT_CYCLES(UNIT_CYCLES)
  ) u_tick (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_restart (w_restart),
    .o_tick    (w_tick)
  );

  // Playback state machine with registered key, pop strobe and busy flag.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_shreg <= '0;
      r_elems <= '0;
      r_units <= '0;
      r_key   <= 1'b0;
      r_next  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_next <= 1'b0;
      if (w_tick) begin
        r_units <= r_units - 3'd1;
      end
      case (r_state)
        ST_IDLE: begin
          if (i_enable && i_valid) begin
            r_shreg <= i_r_data;
            r_next  <= 1'b1;
            r_elems <= '0;
            r_busy  <= 1'b1;
            r_state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (r_elems == 4'(ELEMS_PER_ENTRY)) begin
            r_units <= 3'(CHAR_EXTRA_UNITS);
            r_state <= ST_CHAR_GAP;
          end else begin
            case (w_sym)
              SYM_DOT: begin
                r_units <= 3'(DOT_UNITS);
                r_key   <= 1'b1;
                r_state <= ST_MARK;
              end
              SYM_DASH: begin
                r_units <= 3'(DASH_UNITS);
                r_key   <= 1'b1;
                r_state <= ST_MARK;
              end
              SYM_WORD: begin
                r_units <= 3'(WORD_UNITS);
                r_state <= ST_WORD_GAP;
              end
              default: begin
                if (r_elems == '0) begin
                  r_busy  <= 1'b0;
                  r_state <= ST_IDLE;
                end else begin
                  r_units <= 3'(CHAR_EXTRA_UNITS);
                  r_state <= ST_CHAR_GAP;
                end
              end
            endcase
          end
        end
        ST_MARK: begin
          if (w_expire) begin
            r_key   <= 1'b0;
            r_shreg <= {2'b00, r_shreg[19:2]};
            r_elems <= r_elems + 4'd1;
            r_units <= 3'(INTRA_UNITS);
            r_state <= ST_SPACE;
          end
        end
        ST_SPACE: begin
          if (w_expire) begin
            r_state <= ST_LOAD;
          end
        end
        ST_CHAR_GAP, ST_WORD_GAP: begin
          if (w_expire) begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_key    = r_key;
  assign o_r_next = r_next;
  assign o_busy   = r_busy;

endmodule

// File: tb/tb_morse_player.sv
// Self-checking bench for morse_player with a timeline reference model.
module tb_morse_player;

  localparam int unsigned U = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        valid;
  logic [19:0] data;
  logic        r_next;
  logic        key;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  // Expected per-cycle outputs after acceptance: {r_next, busy, key}.
  logic [2:0] exp_q[$];

  always #5 clk = ~clk;

  morse_player #(.UNIT_CYCLES(U)) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_enable (en),
    .i_valid  (valid),
    .i_r_data (data),
    .o_r_next (r_next),
    .o_key    (key),
    .o_busy   (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic void push(input int unsigned n, input logic [2:0] v);
    for (int unsigned i = 0; i < n; i++) exp_q.push_back(v);
  endfunction

  // Timeline from the Morse rules: each mark is followed by one space unit
  // and one decode cycle; the entry closes with a char gap, a word gap or nothing.
  function automatic void build(input logic [19:0] d);
    logic [1:0] code;
    int unsigned term;
    bit done;
    exp_q.delete();
    push(1, 3'b110);
    term = 1;
    done = 0;
    for (int k = 0; k < 10 && !done; k++) begin
      code = d[2*k +: 2];
      if (code == 2'b01 || code == 2'b10) begin
        push((code == 2'b01 ? 1 : 3) * U, 3'b011);
        push(U, 3'b010);
        push(1, 3'b010);
      end else if (code == 2'b11) begin
        term = 2;
        done = 1;
      end else begin
        term = (k == 0) ? 0 : 1;
        done = 1;
      end
    end
    if (term == 1) push(2 * U, 3'b010);
    if (term == 2) push(7 * U, 3'b010);
    push(1, 3'b000);
  endfunction

  task automatic play(input logic [19:0] d, input bit rnd);
    logic [2:0] got;
    data  = d;
    valid = 1'b1;
    en    = 1'b1;
    step();
    build(d);
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i > 0) step();
      got = {r_next, busy, key};
      check($sformatf("entry %05h cyc %0d {next,busy,key}", d, i), 32'(got), 32'(exp_q[i]));
      if (rnd && i < exp_q.size() - 1) begin
        en    = 1'($urandom_range(0, 1));
        valid = 1'($urandom_range(0, 1));
        data  = 20'($urandom);
      end else begin
        en    = 1'b0;
        valid = 1'b0;
      end
    end
  endtask

  function automatic logic [19:0] rand_entry();
    logic [19:0] d;
    int unsigned n;
    if ($urandom_range(0, 2) == 0) return 20'($urandom);
    d = '0;
    n = $urandom_range(0, 10);
    for (int unsigned k = 0; k < n; k++) d[2*k +: 2] = 2'($urandom_range(1, 2));
    if (n < 10 && $urandom_range(0, 2) == 0) d[2*n +: 2] = 2'b11;
    return d;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; en = 1'b0; valid = 1'b0; data = '0;
    step(); step();
    check("reset key", 32'(key), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset r_next", 32'(r_next), 32'd0);

    // reset coinciding with a would-be acceptance
    en = 1'b1; valid = 1'b1; data = 20'h00001;
    step();
    check("rst+accept r_next", 32'(r_next), 32'd0);
    check("rst+accept busy", 32'(busy), 32'd0);
    rst = 1'b0; en = 1'b0; valid = 1'b0;
    step();
    check("after rst idle r_next", 32'(r_next), 32'd0);

    play(20'h00001, 0);
    play(20'h00009, 0);
    play(20'hAAAAA, 0);
    play(20'h00003, 0);
    play(20'h00000, 0);

    // empty entries with valid held: a pop every other cycle, no key
    data = '0; en = 1'b1; valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      check($sformatf("empty stream r_next %0d", i), 32'(r_next), 32'(i % 2 == 0));
      check($sformatf("empty stream busy %0d", i), 32'(busy), 32'(i % 2 == 0));
      check($sformatf("empty stream key %0d", i), 32'(key), 32'd0);
    end
    en = 1'b0; valid = 1'b0;
    step(); step();
    check("empty drain busy", 32'(busy), 32'd0);
    check("empty drain r_next", 32'(r_next), 32'd0);

    // reset in the middle of a dash
    data = 20'h00002; en = 1'b1; valid = 1'b1;
    step();
    en = 1'b0; valid = 1'b0;
    repeat (5) step();
    check("mid dash key", 32'(key), 32'd1);
    rst = 1'b1; en = 1'b1; valid = 1'b1;
    step();
    check("mid rst key", 32'(key), 32'd0);
    check("mid rst busy", 32'(busy), 32'd0);
    check("mid rst r_next", 32'(r_next), 32'd0);
    rst = 1'b0;
    play(20'h00009, 0);

    for (int i = 0; i < 30; i++) play(rand_entry(), 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
